// File: rtl/jk_register_bank_if.sv
// Bus bundle for jk_register_bank: control, per-bit J/K inputs and registered outputs.
// Optional parity signal present only when JKBANK_PARITY_EN is defined.
interface jk_register_bank_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] changed;
  logic             sr_err;
`ifdef JKBANK_PARITY_EN
  logic             parity;
`endif

`ifdef JKBANK_PARITY_EN
  modport master (output clr, en, mode, J, K, input Q, changed, sr_err, parity);
  modport slave  (input clr, en, mode, J, K, output Q, changed, sr_err, parity);
`else
  modport master (output clr, en, mode, J, K, input Q, changed, sr_err);
  modport slave  (input clr, en, mode, J, K, output Q, changed, sr_err);
`endif
endinterface

// File: rtl/jk_register_bank.sv
// Bank of WIDTH independent flip-flops selectable per cycle as JK, T, D or SR.
// Define JKBANK_PARITY_EN to add a registered even-parity output of Q.
module jk_register_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                clk,
  input logic                rst_n,
  jk_register_bank_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_T  = 2'b01,
    MODE_D  = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] changed_q;
  logic             sr_err_q;
  logic [WIDTH-1:0] next_q;
  logic             next_err;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    next_q   = q;
    next_err = 1'b0;
    if (bus.clr) begin
      next_q = '0;
    end else if (bus.en) begin
      case (mode_e'(bus.mode))
        MODE_JK: next_q = (bus.J & ~q) | (~bus.K & q);
        MODE_T:  next_q = q ^ bus.J;
        MODE_D:  next_q = bus.J;
        MODE_SR: begin
          // S=R=1 falls into the hold term, so an illegal bit never disturbs its neighbours.
          next_q   = (bus.J & ~bus.K) | (q & ~(bus.J ^ bus.K));
          next_err = |(bus.J & bus.K);
        end
        default: next_q = q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= RESET_VAL;
      changed_q <= '0;
      sr_err_q  <= 1'b0;
    end else begin
      q         <= next_q;
      changed_q <= next_q ^ q;
      sr_err_q  <= next_err;
    end
  end

  assign bus.Q       = q;
  assign bus.changed = changed_q;
  assign bus.sr_err  = sr_err_q;

`ifdef JKBANK_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= ^RESET_VAL;
    else        parity_q <= ^next_q;
  end

  assign bus.parity = parity_q;
`endif

endmodule

// File: tb/tb_jk_register_bank.sv
// Self-checking bench for jk_register_bank (WIDTH=8, RESET_VAL=A5): directed vector table,
// reset corner sequences and randomized traffic against a per-bit behavioural model.
module tb_jk_register_bank;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  jk_register_bank_if #(.WIDTH(W)) bus ();

  jk_register_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       clr;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] exp_q;
    logic [7:0] exp_changed;
    logic       exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic e, input logic [1:0] m,
                       input logic [7:0] j, input logic [7:0] k);
    bus.clr  = c;
    bus.en   = e;
    bus.mode = m;
    bus.J    = j;
    bus.K    = k;
  endtask

  task automatic check_outputs(input string name, input logic [7:0] q,
                               input logic [7:0] ch, input logic err);
    check({name, "_q"}, 64'(bus.Q), 64'(q));
    check({name, "_changed"}, 64'(bus.changed), 64'(ch));
    check({name, "_sr_err"}, 64'(bus.sr_err), 64'(err));
`ifdef JKBANK_PARITY_EN
    check({name, "_parity"}, 64'(bus.parity), 64'(^q));
`endif
  endtask

  // Reference: each bit evaluated on its own from the mode truth tables.
  function automatic logic [7:0] model_next(input logic [7:0] q, input logic c, input logic e,
                                            input logic [1:0] m, input logic [7:0] j,
                                            input logic [7:0] k);
    logic [7:0] r;
    if (c) return 8'h00;
    if (!e) return q;
    for (int i = 0; i < W; i++) begin
      case (m)
        2'd0: case ({j[i], k[i]})
                2'b00: r[i] = q[i];
                2'b01: r[i] = 1'b0;
                2'b10: r[i] = 1'b1;
                default: r[i] = ~q[i];
              endcase
        2'd1: r[i] = j[i] ? ~q[i] : q[i];
        2'd2: r[i] = j[i];
        default: if (j[i] && !k[i]) r[i] = 1'b1;
                 else if (!j[i] && k[i]) r[i] = 1'b0;
                 else r[i] = q[i];
      endcase
    end
    return r;
  endfunction

  function automatic logic model_err(input logic c, input logic e, input logic [1:0] m,
                                     input logic [7:0] j, input logic [7:0] k);
    if (c || !e || m != 2'd3) return 1'b0;
    for (int i = 0; i < W; i++)
      if (j[i] && k[i]) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic [7:0] mq, nq;
    logic       ne;
    logic       c, e;
    logic [1:0] m;
    logic [7:0] j, k;

    vecs[0]  = '{"jk_set_clr",   1'b0, 1'b1, 2'd0, 8'hF0, 8'h0F, 8'hF0, 8'h55, 1'b0};
    vecs[1]  = '{"jk_toggle",    1'b0, 1'b1, 2'd0, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 1'b0};
    vecs[2]  = '{"t_toggle",     1'b0, 1'b1, 2'd1, 8'h81, 8'hFF, 8'h8E, 8'h81, 1'b0};
    vecs[3]  = '{"sr_illegal",   1'b0, 1'b1, 2'd3, 8'h03, 8'h01, 8'h8E, 8'h00, 1'b1};
    vecs[4]  = '{"sr_err_drop",  1'b0, 1'b0, 2'd3, 8'h03, 8'h01, 8'h8E, 8'h00, 1'b0};
    vecs[5]  = '{"clr_wins",     1'b1, 1'b1, 2'd2, 8'hFF, 8'h00, 8'h00, 8'h8E, 1'b0};
    vecs[6]  = '{"hold_zero",    1'b0, 1'b0, 2'd2, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[7]  = '{"d_load",       1'b0, 1'b1, 2'd2, 8'h07, 8'hFF, 8'h07, 8'h07, 1'b0};
    vecs[8]  = '{"jk_hold",      1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 8'h07, 8'h00, 1'b0};
    vecs[9]  = '{"sr_set_clr",   1'b0, 1'b1, 2'd3, 8'hF0, 8'h01, 8'hF6, 8'hF1, 1'b0};
    vecs[10] = '{"sr_all_bad",   1'b0, 1'b1, 2'd3, 8'hFF, 8'hFF, 8'hF6, 8'h00, 1'b1};
    vecs[11] = '{"clr_no_en",    1'b1, 1'b0, 2'd3, 8'hFF, 8'hFF, 8'h00, 8'hF6, 1'b0};

    // Reset held across edges with active stimulus: outputs stay at reset values.
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 2'd2, 8'h3C, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("in_reset", RV, 8'h00, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    #2;
    check_outputs("after_release", RV, 8'h00, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].en, vecs[i].mode, vecs[i].j, vecs[i].k);
      @(posedge clk);
      #1;
      check_outputs(vecs[i].name, vecs[i].exp_q, vecs[i].exp_changed, vecs[i].exp_err);
    end

    // Mid-cycle async reset while clr/en are active, then resume on the next edge.
    drive(1'b0, 1'b1, 2'd0, 8'hFF, 8'hFF);
    @(posedge clk);
    #1;
    check_outputs("pre_async", 8'hFF, 8'hFF, 1'b0);
    drive(1'b1, 1'b1, 2'd2, 8'h3C, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", RV, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("reset_over_clr", RV, 8'h00, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 2'd2, 8'h3C, 8'h00);
    @(posedge clk);
    #1;
    check_outputs("resume", 8'h3C, 8'h99, 1'b0);

    mq = 8'h3C;
    for (int n = 0; n < 400; n++) begin
      c = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 3) != 0);
      m = 2'($urandom_range(0, 3));
      j = 8'($urandom);
      k = 8'($urandom);
      drive(c, e, m, j, k);
      nq = model_next(mq, c, e, m, j, k);
      ne = model_err(c, e, m, j, k);
      @(posedge clk);
      #1;
      check_outputs("rand", nq, nq ^ mq, ne);
      mq = nq;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_register_bank.md
JK_REGISTER_BANK -- requirements
Module: jk_register_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of flip-flop bits in the bank (legal range 1..64).
REQ-002 The block SHALL have parameter RESET_VAL, default 0 (WIDTH bits), giving the value Q takes on reset.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port clr, input, 1 bit, synchronous clear.
REQ-006 The block SHALL have port en, input, 1 bit, update enable.
REQ-007 The block SHALL have port mode, input, 2 bits, per-cycle bank mode: 00 JK, 01 T, 10 D, 11 SR.
REQ-008 The block SHALL have port J, input, WIDTH bits, per-bit J / T / D / S input depending on mode.
REQ-009 The block SHALL have port K, input, WIDTH bits, per-bit K / R input; ignored in T and D modes.
REQ-010 The block SHALL have port Q, output, WIDTH bits, registered bank state.
REQ-011 The block SHALL have port changed, output, WIDTH bits, registered per-bit flag: bit flipped on the last clock edge.
REQ-012 The block SHALL have port sr_err, output, 1 bit, registered flag: an illegal S=R=1 occurred on the last edge.

Function
REQ-013 Update priority on each rising clk edge SHALL be: clr, then en, then hold.
REQ-014 With clr=1, Q SHALL become all-zero regardless of en, mode, J and K; sr_err SHALL become 0.
REQ-015 With clr=0 and en=0, Q SHALL hold and sr_err SHALL become 0.
REQ-016 With clr=0 and en=1, each bit i SHALL update independently per mode, using J[i] and K[i].
REQ-017 JK mode (00): {J,K}=00 hold, 01 clear to 0, 10 set to 1, 11 toggle.
REQ-018 T mode (01): J=1 toggle, J=0 hold; K ignored.
REQ-019 D mode (10): Q[i] SHALL take J[i]; K ignored.
REQ-020 SR mode (11): S=1,R=0 set; S=0,R=1 clear; 00 hold; 11 hold that bit.
REQ-021 sr_err SHALL be 1 for exactly the cycle following an SR-mode update in which any bit had J=K=1, and 0 otherwise.
REQ-022 changed SHALL be registered on the same edge as Q and equal next-Q XOR current-Q; this includes flips caused by clr.
REQ-023 Latency from input to Q, changed and sr_err SHALL be one clock edge; no output SHALL depend combinationally on any input.
REQ-024 Bits SHALL be fully independent: an SR-illegal bit SHALL NOT affect the update of other bits in the same cycle.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously set Q=RESET_VAL, changed=0, sr_err=0 (and parity per REQ-029).
REQ-026 The block SHALL hold all outputs at their reset values while rst_n=0 and resume normal updates from the first rising clk edge after rst_n deasserts.
REQ-027 Reset asserted mid-operation SHALL override any clr/en activity in that cycle.

Configuration
REQ-028 Macro JKBANK_PARITY_EN SHALL control an optional parity feature.
REQ-029 When JKBANK_PARITY_EN is defined, output port parity (1 bit) SHALL exist and be registered with Q, equal to the XOR-reduction of the new Q; its reset value SHALL be the XOR of RESET_VAL.
REQ-030 When JKBANK_PARITY_EN is not defined, the parity port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (WIDTH=8, RESET_VAL=8'hA5)
REQ-031 rst_n low mid-cycle -> Q=A5, changed=00, sr_err=0 immediately, without a clk edge.
REQ-032 Q=A5, en=1, mode=00, J=F0, K=0F: the J/K pattern sets the upper nibble and clears the lower nibble -> Q=F0, changed=55.
REQ-033 Q=F0, en=1, mode=00, J=FF, K=FF: the pattern toggles every bit -> Q=0F, changed=FF. Repeat the same stimulus with mode=01, J=81 -> Q=8E, changed=81.
REQ-034 Q=8E, mode=11, J=03, K=01: bit0 has S=R=1 and holds, bit1 is set -> Q=8E, changed=00, sr_err=1 for one cycle; next cycle with en=0 -> sr_err=0.
REQ-035 Q=8E, clr=1, en=1, mode=10, J=FF: clr wins -> Q=00, changed=8E. Next, en=0, clr=0 -> Q holds 00, changed=00.
REQ-036 With JKBANK_PARITY_EN defined: the reset parity output is 0 (A5 has even weight); mode=10, J=07 -> parity=1 on the same edge as Q=07.
